// File: rtl/simple_cache_arbiter.sv
// simple_cache_arbiter: shares the single simple-cache port between the core's
// instruction and data interfaces. One transaction in flight, round-robin on
// ties, watchdog abort with a sticky error flag, saturating per-port grant counters.
module simple_cache_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    cache_req_o,
  output logic [ADDR_WIDTH-1:0]   cache_addr_o,
  output logic                    cache_we_o,
  output logic [DATA_WIDTH/8-1:0] cache_be_o,
  output logic [DATA_WIDTH-1:0]   cache_wdata_o,
  input  logic                    cache_gnt_i,
  input  logic                    cache_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   cache_rdata_i,
  output logic                    timeout_err_o,
  output logic [CNT_WIDTH-1:0]    instr_grants_o,
  output logic [CNT_WIDTH-1:0]    data_grants_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  cache_req_q, cache_req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  icnt_q, icnt_d;
  logic [CNT_WIDTH-1:0]  dcnt_q, dcnt_d;

  logic                  win_s;
  logic                  gnt_s;
  logic                  rvalid_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  timeout_s;

  // Counters stick at all ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_WIDTH'(1);
    end
  endfunction

  // Next-state, latching, watchdog and response logic for the single in-flight transaction.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    icnt_d    = icnt_q;
    dcnt_d    = dcnt_q;
    win_s     = PORT_INSTR;
    gnt_s     = 1'b0;
    rvalid_s  = 1'b0;
    rdata_s   = '0;
    timeout_s = (wdog_q == WD_LIMIT);

    case (state_q)
      S_IDLE: begin
        if (instr_req_i && data_req_i) begin
          win_s = ~last_q;
        end else if (data_req_i) begin
          win_s = PORT_DATA;
        end else begin
          win_s = PORT_INSTR;
        end
        if (instr_req_i || data_req_i) begin
          owner_d = win_s;
          state_d = S_REQ;
          if (win_s == PORT_DATA) begin
            addr_d  = data_addr_i;
            we_d    = data_we_i;
            be_d    = data_be_i;
            wdata_d = data_wdata_i;
          end else begin
            addr_d  = instr_addr_i;
            we_d    = 1'b0;
            be_d    = '1;
            wdata_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An abort still hands the owner its grant so the master can move on.
        if (timeout_s) begin
          gnt_s    = 1'b1;
          rvalid_s = 1'b1;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else if (cache_gnt_i) begin
          gnt_s   = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (cache_rvalid_i) begin
          rvalid_s = 1'b1;
          rdata_s  = cache_rdata_i;
          state_d  = S_IDLE;
        end else if (timeout_s) begin
          rvalid_s = 1'b1;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (gnt_s) begin
      last_d = owner_q;
      if (owner_q == PORT_INSTR) begin
        icnt_d = sat_inc(icnt_q);
      end else begin
        dcnt_d = sat_inc(dcnt_q);
      end
    end else begin
      last_d = last_d;
    end

    if (state_d == S_IDLE) begin
      wdog_d = '0;
    end else if (state_q == S_IDLE) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WD_W'(1);
    end

    cache_req_d = (state_d == S_REQ);
  end

  // State and latched-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= PORT_INSTR;
      last_q      <= PORT_DATA;
      cache_req_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      icnt_q      <= '0;
      dcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cache_req_q <= cache_req_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      icnt_q      <= icnt_d;
      dcnt_q      <= dcnt_d;
    end
  end

  assign cache_req_o    = cache_req_q;
  assign cache_addr_o   = addr_q;
  assign cache_we_o     = we_q;
  assign cache_be_o     = be_q;
  assign cache_wdata_o  = wdata_q;
  assign timeout_err_o  = err_q;
  assign instr_grants_o = icnt_q;
  assign data_grants_o  = dcnt_q;

  assign instr_gnt_o    = gnt_s & (owner_q == PORT_INSTR);
  assign data_gnt_o     = gnt_s & (owner_q == PORT_DATA);
  assign instr_rvalid_o = rvalid_s & (owner_q == PORT_INSTR);
  assign data_rvalid_o  = rvalid_s & (owner_q == PORT_DATA);
  assign instr_rdata_o  = (rvalid_s && owner_q == PORT_INSTR) ? rdata_s : '0;
  assign data_rdata_o   = (rvalid_s && owner_q == PORT_DATA) ? rdata_s : '0;

endmodule

// File: tb/tb_simple_cache_arbiter.sv
// Directed bench for simple_cache_arbiter, built with TIMEOUT_CYCLES=16, CNT_WIDTH=4.
module tb_simple_cache_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_req, instr_gnt, instr_rvalid;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_rdata;
  logic          data_req, data_we, data_gnt, data_rvalid;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_be;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          cache_req, cache_we, cache_gnt, cache_rvalid;
  logic [AW-1:0] cache_addr;
  logic [3:0]    cache_be;
  logic [DW-1:0] cache_wdata, cache_rdata;
  logic          timeout_err;
  logic [CW-1:0] instr_grants, data_grants;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simple_cache_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .cache_req_o(cache_req), .cache_addr_o(cache_addr), .cache_we_o(cache_we),
    .cache_be_o(cache_be), .cache_wdata_o(cache_wdata),
    .cache_gnt_i(cache_gnt), .cache_rvalid_i(cache_rvalid), .cache_rdata_i(cache_rdata),
    .timeout_err_o(timeout_err), .instr_grants_o(instr_grants), .data_grants_o(data_grants)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_be = 4'h0; data_wdata = '0;
    cache_gnt = 1'b0; cache_rvalid = 1'b0; cache_rdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cache_req"}, {31'd0, cache_req}, 32'd0);
    chk({tag, "_cache_addr"}, cache_addr, 32'd0);
    chk({tag, "_cache_we_be"}, {27'd0, cache_we, cache_be}, 32'd0);
    chk({tag, "_cache_wdata"}, cache_wdata, 32'd0);
    chk({tag, "_gnt_rvalid"}, {28'd0, instr_gnt, data_gnt, instr_rvalid, data_rvalid}, 32'd0);
    chk({tag, "_rdata"}, instr_rdata | data_rdata, 32'd0);
    chk({tag, "_err"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_cnts"}, {24'd0, instr_grants, data_grants}, 32'd0);
  endtask

  // One instruction fetch: request in IDLE, grant in first REQ cycle, data next cycle.
  task automatic instr_txn(input logic [31:0] a, input logic [31:0] d, input string tag);
    @(negedge clk); cache_rvalid = 1'b0; instr_req = 1'b1; instr_addr = a;
    @(negedge clk); cache_gnt = 1'b1; #1;
    chk({tag, "_gnt"}, {31'd0, instr_gnt}, 32'd1);
    @(negedge clk); instr_req = 1'b0; cache_gnt = 1'b0; cache_rvalid = 1'b1; cache_rdata = d; #1;
    chk({tag, "_rvalid"}, {31'd0, instr_rvalid}, 32'd1);
    chk({tag, "_rdata"}, instr_rdata, d);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk_zero("reset");

    // 1: instruction only
    @(negedge clk); instr_req = 1'b1; instr_addr = 32'h100; #1;
    chk("t1_idle_req", {31'd0, cache_req}, 32'd0);
    @(negedge clk); cache_gnt = 1'b1; #1;
    chk("t1_cache_req", {31'd0, cache_req}, 32'd1);
    chk("t1_cache_addr", cache_addr, 32'h100);
    chk("t1_we_be", {27'd0, cache_we, cache_be}, 32'h0F);
    chk("t1_gnts", {30'd0, instr_gnt, data_gnt}, 32'h2);
    @(negedge clk); instr_req = 1'b0; cache_gnt = 1'b0; cache_rvalid = 1'b1; cache_rdata = 32'hCAFE0001; #1;
    chk("t1_rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'h2);
    chk("t1_rdata", instr_rdata, 32'hCAFE0001);
    chk("t1_data_rdata", data_rdata, 32'h0);
    chk("t1_wait_req", {31'd0, cache_req}, 32'd0);
    chk("t1_cnt", {28'd0, instr_grants}, 32'd1);
    @(negedge clk); cache_rvalid = 1'b0; #1;
    chk("t1_after", {31'd0, instr_rvalid}, 32'd0);
    chk("t1_after_rdata", instr_rdata, 32'h0);

    // 2: tie from reset, strict alternation
    @(negedge clk); rst_n = 1'b0; idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t != 0) @(negedge clk);
      cache_rvalid = 1'b0; instr_req = 1'b1; instr_addr = 32'h400;
      data_req = 1'b1; data_addr = 32'h800; data_we = 1'b1; data_be = 4'hF; data_wdata = 32'h12345678;
      #1;
      chk("t2_idle_req", {31'd0, cache_req}, 32'd0);
      @(negedge clk); cache_gnt = 1'b1; #1;
      chk("t2_gnts", {30'd0, instr_gnt, data_gnt}, (t % 2 == 0) ? 32'h2 : 32'h1);
      chk("t2_we", {31'd0, cache_we}, (t % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_be", {28'd0, cache_be}, 32'hF);
      chk("t2_wdata", cache_wdata, (t % 2 == 0) ? 32'h0 : 32'h12345678);
      chk("t2_addr", cache_addr, (t % 2 == 0) ? 32'h400 : 32'h800);
      @(negedge clk); cache_gnt = 1'b0; cache_rvalid = 1'b1; cache_rdata = 32'hD0 + t; #1;
      chk("t2_rvalids", {30'd0, instr_rvalid, data_rvalid}, (t % 2 == 0) ? 32'h2 : 32'h1);
      chk("t2_rdata", (t % 2 == 0) ? instr_rdata : data_rdata, 32'hD0 + t);
    end
    @(negedge clk); idle_inputs(); #1;
    chk("t2_cnts", {24'd0, instr_grants, data_grants}, 32'h33);

    // 3: data write, rvalid during REQ ignored, inputs changed after latch
    @(negedge clk); data_req = 1'b1; data_we = 1'b1; data_addr = 32'h2000; data_be = 4'h3; data_wdata = 32'hA5A5;
    @(negedge clk); data_addr = 32'h3000; data_we = 1'b0; cache_rvalid = 1'b1; cache_rdata = 32'h55; #1;
    chk("t3_addr_latched", cache_addr, 32'h2000);
    chk("t3_we", {31'd0, cache_we}, 32'd1);
    chk("t3_be", {28'd0, cache_be}, 32'h3);
    chk("t3_early_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'h0);
    chk("t3_no_gnt_yet", {30'd0, instr_gnt, data_gnt}, 32'h0);
    @(negedge clk); cache_rvalid = 1'b0; cache_gnt = 1'b1; #1;
    chk("t3_gnt", {30'd0, instr_gnt, data_gnt}, 32'h1);
    @(negedge clk); data_req = 1'b0; cache_gnt = 1'b0; cache_rvalid = 1'b1; cache_rdata = 32'h0; #1;
    chk("t3_rvalids", {30'd0, instr_rvalid, data_rvalid}, 32'h1);
    @(negedge clk); idle_inputs();

    // 4: watchdog abort
    instr_req = 1'b1; instr_addr = 32'h500;
    for (int k = 1; k < TO; k++) @(negedge clk);
    #1;
    chk("t4_pre_gnt", {31'd0, instr_gnt}, 32'd0);
    chk("t4_pre_req", {31'd0, cache_req}, 32'd1);
    chk("t4_pre_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk); cache_rdata = 32'hBAD; #1;
    chk("t4_abort_gnt_rv", {30'd0, instr_gnt, instr_rvalid}, 32'h3);
    chk("t4_abort_rdata", instr_rdata, 32'h0);
    chk("t4_abort_data", {30'd0, data_gnt, data_rvalid}, 32'h0);
    @(negedge clk); instr_req = 1'b0; cache_gnt = 1'b1; cache_rvalid = 1'b1; #1;
    chk("t4_late_ignored", {30'd0, instr_gnt, instr_rvalid}, 32'h0);
    chk("t4_req_dropped", {31'd0, cache_req}, 32'd0);
    chk("t4_err", {31'd0, timeout_err}, 32'd1);
    @(negedge clk); idle_inputs(); #1;
    chk("t4_err_sticky", {31'd0, timeout_err}, 32'd1);

    // 5: reset while waiting for data
    @(negedge clk); instr_req = 1'b1; instr_addr = 32'h600;
    @(negedge clk); cache_gnt = 1'b1;
    @(negedge clk); instr_req = 1'b0; cache_gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk_zero("t5_reset");
    @(negedge clk); cache_rvalid = 1'b1; cache_rdata = 32'h99; #1;
    chk("t5_stale_rvalid", {31'd0, instr_rvalid}, 32'd0);
    instr_txn(32'h700, 32'h77, "t5_txn");
    @(negedge clk); idle_inputs(); #1;
    chk("t5_cnt", {28'd0, instr_grants}, 32'd1);

    // 6: grant counter saturation
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr_txn(32'h1000 + 4 * i, 32'hE000 + i, "t6_txn");
      if (i == 14) chk("t6_cnt15", {28'd0, instr_grants}, 32'd15);
    end
    @(negedge clk); idle_inputs(); #1;
    chk("t6_cnt_sat", {28'd0, instr_grants}, 32'd15);
    chk("t6_data_cnt", {28'd0, data_grants}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "bench time limit reached");
  end
endmodule
